// File: rtl/song_play_ctrl_pkg.sv
// Shared definitions for the song playback sequencer: FSM state encoding,
// note code width and the silent note code.
package song_play_ctrl_pkg;

  // Playback states; the encoding is visible on the state output port.
  typedef enum logic [1:0] {
    SSTOP  = 2'd0,
    SPLAY  = 2'd1,
    SPAUSE = 2'd2
  } play_state_e;

  // Note codes: 0 = silence, 1-21 = low/middle/high scale.
  localparam int NOTE_W = 5;

  typedef logic [NOTE_W-1:0] note_t;

  localparam note_t SILENCE = 5'd0;

endpackage : song_play_ctrl_pkg

// File: rtl/song_play_ctrl_beat_timer.sv
// Note-period tick counter. Counts 0..TICKS_PER_NOTE-1 while enabled, wraps
// to 0 after the terminal count, and can be cleared synchronously. Besides
// the terminal-count and tick==1 flags it exposes the next tick value so the
// parent can register outputs that must line up with the tick register.
module song_play_ctrl_beat_timer #(
  parameter int TICKS_PER_NOTE = 25_000_000,
  parameter int TICK_W         = 25
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              en,
  input  logic              clr,
  output logic [TICK_W-1:0] tick_next,
  output logic              tc,
  output logic              at_one
);

  localparam logic [TICK_W-1:0] LAST_TICK = TICK_W'(TICKS_PER_NOTE - 1);
  localparam logic [TICK_W-1:0] ONE_TICK  = TICK_W'(1);

  logic [TICK_W-1:0] tick_q;

  assign tc     = (tick_q == LAST_TICK);
  assign at_one = (tick_q == ONE_TICK);

  // Next tick: clear wins over enable; the wrap is explicit at the terminal
  // count rather than relying on counter overflow.
  always_comb begin
    // NOTE: every signal driven here gets a default first, so no path through
    // the block leaves it unassigned and no latch is inferred.
    tick_next = tick_q;
    if (clr) begin
      tick_next = '0;
    end else if (en) begin
      tick_next = tc ? '0 : tick_q + 1'b1;
    end
  end

  // Tick register with asynchronous active-low reset.
  always_ff @(posedge clk or negedge reset) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples values from before the edge, independent of statement order.
    if (!reset) begin
      tick_q <= '0;
    end else begin
      tick_q <= tick_next;
    end
  end

endmodule : song_play_ctrl_beat_timer

// File: rtl/song_play_ctrl.sv
// Playback sequencer for the song ROM. Turns play/pause/stop pulses into a
// play state, steps the ROM address once per note period, latches each note
// and forwards it to the tone generator with a silent gap at the end of every
// note so repeated notes are heard separately.
module song_play_ctrl
  import song_play_ctrl_pkg::*;
#(
  parameter int TICKS_PER_NOTE = 25_000_000,
  parameter int GAP_TICKS      = 1_000_000,
  parameter int SONG_LEN       = 64,
  parameter int ADDR_W         = 6
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              play_btn,
  input  logic              pause_btn,
  input  logic              stop_btn,
  input  logic              loop_en,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [4:0]        rom_note,
  output logic [4:0]        note_out,
  output logic [1:0]        state,
  output logic              note_strobe,
  output logic              song_done
);

  localparam int TICK_W = (TICKS_PER_NOTE > 1) ? $clog2(TICKS_PER_NOTE) : 1;

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(SONG_LEN - 1);
  // Audible window: the note is captured at tick 1, so it can sound from
  // tick 2 up to the start of the end-of-note gap.
  localparam logic [TICK_W-1:0] WIN_LO    = TICK_W'(2);
  localparam logic [TICK_W-1:0] WIN_HI    = TICK_W'(TICKS_PER_NOTE - GAP_TICKS - 1);

  play_state_e       state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  note_t             cur_note_q, cur_note_d;
  note_t             note_out_q, note_out_d;

  logic [TICK_W-1:0] tick_next;
  logic              tick_tc;
  logic              tick_at_one;
  logic              timer_en;
  logic              timer_clr;
  logic              capture;
  logic              done_pulse;

  // Tick counter: runs only while playing continues, and is held at zero
  // whenever the next state is stopped (which also covers play-from-stop).
  assign timer_en  = (state_q == SPLAY) && (state_d != SPAUSE);
  assign timer_clr = (state_d == SSTOP);

  song_play_ctrl_beat_timer #(
    .TICKS_PER_NOTE(TICKS_PER_NOTE),
    .TICK_W        (TICK_W)
  ) u_beat_timer (
    .clk      (clk),
    .reset    (reset),
    .en       (timer_en),
    .clr      (timer_clr),
    .tick_next(tick_next),
    .tc       (tick_tc),
    .at_one   (tick_at_one)
  );

  // Next-state, address and strobe logic; button priority is stop > pause > play.
  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    capture    = 1'b0;
    done_pulse = 1'b0;
    unique case (state_q)
      SSTOP: begin
        addr_d = '0;
        // pause has no meaning while stopped, so only stop can block play.
        if (play_btn && !stop_btn) begin
          state_d = SPLAY;
        end
      end
      SPLAY: begin
        if (stop_btn) begin
          state_d = SSTOP;
          addr_d  = '0;
        end else if (pause_btn) begin
          state_d = SPAUSE;
        end else begin
          capture = tick_at_one;
          if (tick_tc) begin
            if (addr_q < LAST_ADDR) begin
              addr_d = addr_q + 1'b1;
            end else begin
              done_pulse = 1'b1;
              addr_d     = '0;
              if (!loop_en) begin
                state_d = SSTOP;
              end
            end
          end
        end
      end
      SPAUSE: begin
        if (stop_btn) begin
          state_d = SSTOP;
          addr_d  = '0;
        end else if (play_btn) begin
          state_d = SPLAY;
        end
      end
      default: begin
        state_d = SSTOP;
        addr_d  = '0;
      end
    endcase
  end

  // Note path: the ROM value only ever reaches the tone generator through
  // cur_note, and note_out is computed from next-cycle values so it is aligned
  // with the tick register and changes only on clock edges.
  always_comb begin
    cur_note_d = capture ? note_t'(rom_note) : cur_note_q;
    note_out_d = SILENCE;
    if ((state_d == SPLAY) && (tick_next >= WIN_LO) && (tick_next <= WIN_HI)) begin
      note_out_d = cur_note_d;
    end
  end

  // Sequencer registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= SSTOP;
      addr_q     <= '0;
      cur_note_q <= SILENCE;
      note_out_q <= SILENCE;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      cur_note_q <= cur_note_d;
      note_out_q <= note_out_d;
    end
  end

  assign rom_addr    = addr_q;
  assign state       = state_q;
  assign note_out    = note_out_q;
  assign note_strobe = capture;
  assign song_done   = done_pulse;

endmodule : song_play_ctrl

// File: tb/tb_song_play_ctrl.sv
// Directed bench for song_play_ctrl with a short song: 10 ticks per note,
// 2-tick gap, 4 notes held in a registered behavioural ROM (12,13,13,12).
module tb_song_play_ctrl;

  localparam int TPN = 10;
  localparam int GAP = 2;
  localparam int LEN = 4;
  localparam int AW  = 2;

  logic          clk;
  logic          reset;
  logic          play_btn;
  logic          pause_btn;
  logic          stop_btn;
  logic          loop_en;
  logic [AW-1:0] rom_addr;
  logic [4:0]    rom_note;
  logic [4:0]    note_out;
  logic [1:0]    state;
  logic          note_strobe;
  logic          song_done;

  logic [4:0]    rom_mem [LEN];

  int checks;
  int errors;

  song_play_ctrl #(
    .TICKS_PER_NOTE(TPN),
    .GAP_TICKS     (GAP),
    .SONG_LEN      (LEN),
    .ADDR_W        (AW)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .play_btn   (play_btn),
    .pause_btn  (pause_btn),
    .stop_btn   (stop_btn),
    .loop_en    (loop_en),
    .rom_addr   (rom_addr),
    .rom_note   (rom_note),
    .note_out   (note_out),
    .state      (state),
    .note_strobe(note_strobe),
    .song_done  (song_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    rom_mem[0] = 5'd12;
    rom_mem[1] = 5'd13;
    rom_mem[2] = 5'd13;
    rom_mem[3] = 5'd12;
  end

  // Registered ROM: output reflects the address from one edge earlier.
  always @(posedge clk) rom_note <= rom_mem[rom_addr];

  // Advance one cycle; outputs are then sampled 1 time unit after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  // Expected note_out for a given tick within a period of note n.
  function automatic logic [4:0] exp_note(input int n, input int t);
    return (t >= 2 && t <= TPN - GAP - 1) ? rom_mem[n] : 5'd0;
  endfunction

  task automatic test_reset();
    reset = 1'b0;
    steps(3);
    reset = 1'b1;
    step();
    checks++; if (state !== 2'd0) begin errors++; $display("FAIL reset_state got %0d want 0", state); end
    checks++; if (rom_addr !== 2'd0) begin errors++; $display("FAIL reset_addr got %0d want 0", rom_addr); end
    checks++; if (note_out !== 5'd0) begin errors++; $display("FAIL reset_note got %0d want 0", note_out); end
    checks++; if (note_strobe !== 1'b0 || song_done !== 1'b0) begin
      errors++; $display("FAIL reset_pulses got strobe=%b done=%b want 0 0", note_strobe, song_done);
    end
  endtask

  task automatic test_first_note();
    play_btn = 1'b1; step(); play_btn = 1'b0;
    checks++; if (state !== 2'd1) begin errors++; $display("FAIL play_state got %0d want 1", state); end
    for (int t = 0; t < TPN; t++) begin
      checks++; if (rom_addr !== 2'd0) begin errors++; $display("FAIL n0_addr t=%0d got %0d want 0", t, rom_addr); end
      checks++; if (note_strobe !== (t == 1)) begin errors++; $display("FAIL n0_strobe t=%0d got %b want %b", t, note_strobe, (t == 1)); end
      checks++; if (note_out !== exp_note(0, t)) begin errors++; $display("FAIL n0_note t=%0d got %0d want %0d", t, note_out, exp_note(0, t)); end
      step();
    end
    checks++; if (rom_addr !== 2'd1) begin errors++; $display("FAIL n0_next_addr got %0d want 1", rom_addr); end
  endtask

  task automatic test_repeat_notes();
    for (int n = 1; n <= 2; n++) begin
      int strobes = 0;
      for (int t = 0; t < TPN; t++) begin
        if (note_strobe === 1'b1) strobes++;
        checks++; if (rom_addr !== 2'(n)) begin errors++; $display("FAIL rep_addr n=%0d t=%0d got %0d want %0d", n, t, rom_addr, n); end
        checks++; if (note_out !== exp_note(n, t)) begin errors++; $display("FAIL rep_note n=%0d t=%0d got %0d want %0d", n, t, note_out, exp_note(n, t)); end
        step();
      end
      checks++; if (strobes != 1) begin errors++; $display("FAIL rep_strobes n=%0d got %0d want 1", n, strobes); end
    end
  endtask

  task automatic test_song_end_stop();
    loop_en = 1'b0;
    for (int t = 0; t < TPN; t++) begin
      checks++; if (song_done !== (t == TPN - 1)) begin errors++; $display("FAIL end_done t=%0d got %b want %b", t, song_done, (t == TPN - 1)); end
      checks++; if (note_out !== exp_note(3, t)) begin errors++; $display("FAIL end_note t=%0d got %0d want %0d", t, note_out, exp_note(3, t)); end
      step();
    end
    checks++; if (state !== 2'd0) begin errors++; $display("FAIL end_state got %0d want 0", state); end
    checks++; if (rom_addr !== 2'd0) begin errors++; $display("FAIL end_addr got %0d want 0", rom_addr); end
    checks++; if (note_out !== 5'd0 || song_done !== 1'b0) begin
      errors++; $display("FAIL end_quiet got note=%0d done=%b want 0 0", note_out, song_done);
    end
  endtask

  task automatic test_song_end_loop();
    loop_en = 1'b1;
    play_btn = 1'b1; step(); play_btn = 1'b0;
    for (int n = 0; n < LEN; n++) begin
      for (int t = 0; t < TPN; t++) begin
        checks++; if (song_done !== (n == LEN - 1 && t == TPN - 1)) begin
          errors++; $display("FAIL loop_done n=%0d t=%0d got %b", n, t, song_done);
        end
        step();
      end
    end
    checks++; if (state !== 2'd1) begin errors++; $display("FAIL loop_state got %0d want 1", state); end
    checks++; if (rom_addr !== 2'd0) begin errors++; $display("FAIL loop_addr got %0d want 0", rom_addr); end
    steps(2);
    checks++; if (note_out !== 5'd12) begin errors++; $display("FAIL loop_note got %0d want 12", note_out); end
    loop_en = 1'b0;
    stop_btn = 1'b1; step(); stop_btn = 1'b0;
    checks++; if (state !== 2'd0) begin errors++; $display("FAIL loop_stop got %0d want 0", state); end
  endtask

  task automatic test_pause();
    play_btn = 1'b1; step(); play_btn = 1'b0;
    steps(5);
    checks++; if (note_out !== 5'd12) begin errors++; $display("FAIL pre_pause_note got %0d want 12", note_out); end
    pause_btn = 1'b1; step(); pause_btn = 1'b0;
    for (int i = 0; i < 20; i++) begin
      checks++; if (state !== 2'd2 || note_out !== 5'd0 || rom_addr !== 2'd0 || note_strobe !== 1'b0) begin
        errors++; $display("FAIL pause_hold i=%0d got state=%0d note=%0d addr=%0d strobe=%b", i, state, note_out, rom_addr, note_strobe);
      end
      step();
    end
    play_btn = 1'b1; step(); play_btn = 1'b0;
    checks++; if (state !== 2'd1 || note_out !== 5'd12) begin
      errors++; $display("FAIL resume got state=%0d note=%0d want 1 12", state, note_out);
    end
    steps(4);
    checks++; if (rom_addr !== 2'd0) begin errors++; $display("FAIL resume_tick9_addr got %0d want 0", rom_addr); end
    step();
    checks++; if (rom_addr !== 2'd1) begin errors++; $display("FAIL resume_next_addr got %0d want 1", rom_addr); end
  endtask

  task automatic test_priority();
    stop_btn = 1'b1; pause_btn = 1'b1; play_btn = 1'b1;
    step();
    stop_btn = 1'b0; pause_btn = 1'b0; play_btn = 1'b0;
    checks++; if (state !== 2'd0 || rom_addr !== 2'd0) begin
      errors++; $display("FAIL prio got state=%0d addr=%0d want 0 0", state, rom_addr);
    end
    pause_btn = 1'b1; step(); pause_btn = 1'b0;
    checks++; if (state !== 2'd0) begin errors++; $display("FAIL stop_pause got %0d want 0", state); end
  endtask

  task automatic test_async_reset();
    play_btn = 1'b1; step(); play_btn = 1'b0;
    steps(TPN + 3);
    checks++; if (note_out !== 5'd13 || rom_addr !== 2'd1) begin
      errors++; $display("FAIL pre_reset got note=%0d addr=%0d want 13 1", note_out, rom_addr);
    end
    #2;
    reset = 1'b0;
    #1;
    checks++; if (note_out !== 5'd0 || rom_addr !== 2'd0 || state !== 2'd0) begin
      errors++; $display("FAIL async_reset got note=%0d addr=%0d state=%0d want 0 0 0", note_out, rom_addr, state);
    end
    step();
    reset = 1'b1;
    steps(5);
    checks++; if (note_out !== 5'd0 || rom_addr !== 2'd0 || state !== 2'd0) begin
      errors++; $display("FAIL post_reset got note=%0d addr=%0d state=%0d want 0 0 0", note_out, rom_addr, state);
    end
    play_btn = 1'b1; step(); play_btn = 1'b0;
    checks++; if (state !== 2'd1) begin errors++; $display("FAIL post_reset_play got %0d want 1", state); end
  endtask

  initial begin
    checks    = 0;
    errors    = 0;
    reset     = 1'b0;
    play_btn  = 1'b0;
    pause_btn = 1'b0;
    stop_btn  = 1'b0;
    loop_en   = 1'b0;
    test_reset();
    test_first_note();
    test_repeat_notes();
    test_song_end_stop();
    test_song_end_loop();
    test_pause();
    test_priority();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_song_play_ctrl
